// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
package if_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: one outstanding imem request, redirect
// handling with in-flight response dropping, and a held IFR output slot.
// Optional macro IFP_PERF_CNT_EN adds fetch/redirect performance counters.
module if_pc_gen
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_IFP,
  input  logic            branch_taken_IFP,
  input  logic [XLEN-1:0] branch_target_IFP,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid_IFR,
  output logic [XLEN-1:0] pc_IFR,
  output logic [ILEN-1:0] inst_IFR,
`ifdef IFP_PERF_CNT_EN
  output logic [63:0]     fetch_cnt,
  output logic [63:0]     redirect_cnt,
`endif
  output logic            misalign_IFP
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] pc_ifr_q, pc_ifr_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            misalign_q, misalign_d;
  logic            capture_c;

  // Next-state and datapath update; a redirect outranks every other event.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    pc_ifr_d     = pc_ifr_q;
    inst_d       = inst_q;
    misalign_d   = 1'b0;
    capture_c    = 1'b0;

    if (branch_taken_IFP) begin
      pc_d         = {branch_target_IFP[XLEN-1:2], 2'b00};
      inst_valid_d = 1'b0;
      misalign_d   = |branch_target_IFP[1:0];
      unique case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              capture_c    = 1'b1;
              inst_d       = imem_resp_data;
              pc_ifr_d     = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + XLEN'(4);
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_IFP) begin
            inst_valid_d = 1'b0;
            state_d      = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    req_valid_d = (state_d == ST_REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      pc_ifr_q     <= '0;
      inst_q       <= NOP_INST;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      pc_ifr_q     <= pc_ifr_d;
      inst_q       <= inst_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef IFP_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] redirect_cnt_q, redirect_cnt_d;

  // Counter increments for captured instructions and redirect cycles.
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q + 64'(capture_c);
    redirect_cnt_d = redirect_cnt_q + 64'(branch_taken_IFP);
  end

  // Counter registers, wrapping naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid_IFR = inst_valid_q;
  assign pc_IFR         = pc_ifr_q;
  assign inst_IFR       = inst_q;
  assign misalign_IFP   = misalign_q;

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall_IFP  input  1  from the hazard unit; downstream cannot accept the held instruction.
REQ-005 SHALL have port branch_taken_IFP  input  1  from the hazard unit; redirects fetch.
REQ-006 SHALL have port branch_target_IFP  input  64  redirect address.
REQ-007 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_req_addr  output  64  request address; always equals the pc register.
REQ-009 SHALL have port imem_req_ready  input  1  request accepted when high together with imem_req_valid.
REQ-010 SHALL have port imem_resp_valid  input  1  response data valid; at most one response per accepted request.
REQ-011 SHALL have port imem_resp_data  input  32  fetched instruction.
REQ-012 SHALL have ports inst_valid_IFR  output  1, pc_IFR  output  64, inst_IFR  output  32: the instruction presented to the IFR stage.
REQ-013 SHALL have port misalign_IFP  output  1  one-cycle pulse when a redirect target has bits [1:0] nonzero.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, with at most one outstanding memory request.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-016 REQ SHALL drive imem_req_valid=1; on imem_req_valid&&imem_req_ready it SHALL go to WAIT; imem_req_valid SHALL be 0 in all other states.
REQ-017 WAIT on imem_resp_valid with drop_pending=0 SHALL capture inst_IFR<=imem_resp_data, pc_IFR<=pc, inst_valid_IFR<=1, pc<=pc+4 (64-bit wrap), and go to HOLD.
REQ-018 HOLD SHALL hold all IFR outputs stable while stall_IFP=1; in a cycle with stall_IFP=0 it SHALL clear inst_valid_IFR and go to REQ.
REQ-019 stall_IFP SHALL NOT block REQ or WAIT.
REQ-020 A redirect SHALL set pc<=branch_target_IFP with bits [1:0] forced to 0, clear inst_valid_IFR, and pulse misalign_IFP if the target bits [1:0]!=0.
REQ-021 A redirect SHALL override stall_IFP and every other event in the same cycle.
REQ-022 Redirect in IDLE, HOLD, or in REQ without handshake SHALL go to REQ; imem_req_addr SHALL show the new pc from the next cycle.
REQ-023 Redirect in REQ coinciding with a handshake SHALL go to WAIT with drop_pending=1.
REQ-024 Redirect in WAIT without a response SHALL set drop_pending=1 and stay in WAIT; redirect in WAIT with a response SHALL discard it and go to REQ.
REQ-025 WAIT on imem_resp_valid with drop_pending=1 SHALL discard the data, clear drop_pending, and go to REQ with inst_valid_IFR left at 0.
REQ-026 imem_resp_valid outside WAIT SHALL be ignored.
REQ-027 Best-case throughput SHALL be one instruction per 3 cycles, with a 1-cycle response.

Reset
REQ-028 On rst=1 the block SHALL set state=IDLE, pc=RESET_PC, drop_pending=0, inst_valid_IFR=0, pc_IFR=0, inst_IFR=32'h0000_0013 (NOP), misalign_IFP=0, imem_req_valid=0.
REQ-029 Reset mid-request SHALL abandon the transaction; a stale response arrives outside WAIT or during IDLE and is ignored per REQ-026.

Configuration
REQ-030 With IFP_PERF_CNT_EN defined, the block SHALL add outputs fetch_cnt[63:0] (+1 per captured instruction) and redirect_cnt[63:0] (+1 per redirect cycle), both reset to 0 and wrapping.
REQ-031 Without IFP_PERF_CNT_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package if_pkg SHALL hold the FSM state enum, the NOP_INST constant, and the XLEN=64 and ILEN=32 constants.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Reset with ready=1 and a 1-cycle response: req_addr is 0x8000_0000 on cycle 2; inst_valid_IFR=1 with pc_IFR=0x8000_0000; the next request is to 0x8000_0004.
REQ-035 stall_IFP=1 for 5 cycles in HOLD: outputs stay stable, no new request; the request resumes the cycle after the stall drops.
REQ-036 Redirect to 0x100 while in WAIT, response 2 cycles later: the response is dropped and the next request is to 0x100.
REQ-037 Redirect to 0x103 coinciding with stall_IFP=1 in HOLD: inst_valid_IFR clears, misalign_IFP pulses, the next request is to 0x100.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC fetch: the next pc is 0x0; with IFP_PERF_CNT_EN, fetch_cnt equals the number of captured instructions and redirect_cnt equals the number of redirects.
